// File: rtl/cpu_pkg.sv
// Shared CPU definitions: field widths, opcode/func encodings, flag indices,
// sequencer step codes and the control-strobe bundle.
package cpu_pkg;

  localparam int unsigned OPCODE_WIDTH = 4;
  localparam int unsigned FUNC_WIDTH   = 4;
  localparam int unsigned STATE_WIDTH  = 3;
  localparam int unsigned FLAGS_WIDTH  = 4;

  typedef logic [OPCODE_WIDTH-1:0] opcode_t;
  typedef logic [FUNC_WIDTH-1:0]   func_t;

  // Opcodes (instr_hi[7:4]); 0111 is the single undefined opcode
  localparam opcode_t RTYPE = 4'h0;
  localparam opcode_t ADDI  = 4'h1;
  localparam opcode_t SUBI  = 4'h2;
  localparam opcode_t ANDI  = 4'h3;
  localparam opcode_t ORI   = 4'h4;
  localparam opcode_t XORI  = 4'h5;
  localparam opcode_t CMPI  = 4'h6;
  localparam opcode_t UNDEF = 4'h7;
  localparam opcode_t STACK = 4'h8;
  localparam opcode_t RCALL = 4'h9;
  localparam opcode_t RJMP  = 4'hA;
  localparam opcode_t JE    = 4'hB;
  localparam opcode_t JNE   = 4'hC;
  localparam opcode_t JB    = 4'hD;
  localparam opcode_t JAE   = 4'hE;
  localparam opcode_t JL    = 4'hF;

  // R-type func codes (instr_lo[3:0]); 9..15 are undefined
  localparam func_t ADD = 4'h0;
  localparam func_t SUB = 4'h1;
  localparam func_t AND = 4'h2;
  localparam func_t OR  = 4'h3;
  localparam func_t XOR = 4'h4;
  localparam func_t LSR = 4'h5;
  localparam func_t LSL = 4'h6;
  localparam func_t ASR = 4'h7;
  localparam func_t CMP = 4'h8;

  // Stack-group sub-operations, carried in the func field of STACK
  localparam func_t SF_PUSH  = 4'h0;
  localparam func_t SF_PUSHF = 4'h1;
  localparam func_t SF_POP   = 4'h2;
  localparam func_t SF_POPF  = 4'h3;
  localparam func_t SF_RET   = 4'h4;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    S_FETCH_HI = 3'd0,
    S_FETCH_LO = 3'd1,
    S_2        = 3'd2,
    S_3        = 3'd3,
    S_4        = 3'd4,
    S_5        = 3'd5
  } step_e;

  typedef enum logic [3:0] {
    CL_ALU,
    CL_CMP,
    CL_PUSH,
    CL_PUSHF,
    CL_POP,
    CL_POPF,
    CL_RET,
    CL_RCALL,
    CL_RJMP,
    CL_BRANCH,
    CL_ILLEGAL
  } iclass_e;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic ir_hi_we;
    logic ir_lo_we;
    logic pc_inc;
    logic pc_write;
    logic sp_write;
    logic reg_write;
    logic flags_write;
    logic instr_done;
    logic illegal;
  } strobes_t;

  // Collapse opcode/func into the execute-sequence class
  function automatic iclass_e decode_class(input opcode_t opcode, input func_t func);
    iclass_e cls;
    cls = CL_ILLEGAL;
    case (opcode)
      RTYPE: begin
        case (func)
          ADD, SUB, AND, OR, XOR, LSR, LSL, ASR: cls = CL_ALU;
          CMP:                                   cls = CL_CMP;
          default:                               cls = CL_ILLEGAL;
        endcase
      end
      ADDI, SUBI, ANDI, ORI, XORI: cls = CL_ALU;
      CMPI:                        cls = CL_CMP;
      STACK: begin
        case (func)
          SF_PUSH:  cls = CL_PUSH;
          SF_PUSHF: cls = CL_PUSHF;
          SF_POP:   cls = CL_POP;
          SF_POPF:  cls = CL_POPF;
          SF_RET:   cls = CL_RET;
          default:  cls = CL_ILLEGAL;
        endcase
      end
      RCALL:                   cls = CL_RCALL;
      RJMP:                    cls = CL_RJMP;
      JE, JNE, JB, JAE, JL:    cls = CL_BRANCH;
      default:                 cls = CL_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath/memory bundle: decoded instruction fields and flags in,
// step counter and control strobes out.
interface control_sequencer_if;
  import cpu_pkg::*;

  logic [OPCODE_WIDTH-1:0] opcode;
  logic [FUNC_WIDTH-1:0]   func;
  logic [FLAGS_WIDTH-1:0]  flags;
  logic                    mem_ready;

  logic [STATE_WIDTH-1:0]  state;
  logic                    mem_read;
  logic                    mem_write;
  logic                    ir_hi_we;
  logic                    ir_lo_we;
  logic                    pc_inc;
  logic                    pc_write;
  logic                    sp_write;
  logic                    reg_write;
  logic                    flags_write;
  logic                    instr_done;
  logic                    illegal;

  modport master (
    input  opcode, func, flags, mem_ready,
    output state, mem_read, mem_write, ir_hi_we, ir_lo_we, pc_inc, pc_write,
           sp_write, reg_write, flags_write, instr_done, illegal
  );

  modport slave (
    output opcode, func, flags, mem_ready,
    input  state, mem_read, mem_write, ir_hi_we, ir_lo_we, pc_inc, pc_write,
           sp_write, reg_write, flags_write, instr_done, illegal
  );

endinterface

// File: rtl/branch_cond.sv
// Conditional-branch evaluator: decides whether a Jcc opcode is taken from the
// current {V,N,C,Z} flags. Non-branch opcodes report not-taken.
module branch_cond
  import cpu_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0] opcode_i,
  input  logic [FLAGS_WIDTH-1:0]  flags_i,
  output logic                    take_o
);

  always_comb begin
    take_o = 1'b0;
    case (opcode_i)
      JE:      take_o =  flags_i[FLAG_Z];
      JNE:     take_o = ~flags_i[FLAG_Z];
      JB:      take_o =  flags_i[FLAG_C];
      JAE:     take_o = ~flags_i[FLAG_C];
      JL:      take_o =  flags_i[FLAG_N] ^ flags_i[FLAG_V];
      default: take_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multicycle control FSM: two-byte fetch, decode, per-instruction execute steps.
// Strobes are combinational from the step, decoded class, flags and mem_ready.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  control_sequencer_if.master  bus
);

  step_e    state_q;
  step_e    state_d;
  strobes_t strb;
  iclass_e  cls;
  logic     take;

  assign cls = decode_class(bus.opcode, bus.func);

  branch_cond u_branch_cond (
    .opcode_i (bus.opcode),
    .flags_i  (bus.flags),
    .take_o   (take)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH_HI;
    end else begin
      state_q <= state_d;
    end
  end

  // Next step and strobes; a memory step holds until mem_ready
  always_comb begin
    state_d = state_q;
    strb    = '0;

    case (state_q)
      S_FETCH_HI: begin
        strb.mem_read = 1'b1;
        if (bus.mem_ready) begin
          strb.ir_hi_we = 1'b1;
          strb.pc_inc   = 1'b1;
          state_d       = S_FETCH_LO;
        end
      end

      S_FETCH_LO: begin
        strb.mem_read = 1'b1;
        if (bus.mem_ready) begin
          strb.ir_lo_we = 1'b1;
          strb.pc_inc   = 1'b1;
          state_d       = S_2;
        end
      end

      S_2: begin
        case (cls)
          CL_ALU: begin
            strb.reg_write   = 1'b1;
            strb.flags_write = 1'b1;
            strb.instr_done  = 1'b1;
            state_d          = S_FETCH_HI;
          end
          CL_CMP: begin
            strb.flags_write = 1'b1;
            strb.instr_done  = 1'b1;
            state_d          = S_FETCH_HI;
          end
          CL_PUSH, CL_PUSHF, CL_RCALL: begin
            state_d = S_3;
          end
          CL_POP, CL_POPF, CL_RET: begin
            strb.sp_write = 1'b1;
            state_d       = S_3;
          end
          CL_RJMP: begin
            strb.pc_write   = 1'b1;
            strb.instr_done = 1'b1;
            state_d         = S_FETCH_HI;
          end
          CL_BRANCH: begin
            strb.pc_write   = take;
            strb.instr_done = 1'b1;
            state_d         = S_FETCH_HI;
          end
          default: begin
            strb.illegal    = 1'b1;
            strb.instr_done = 1'b1;
            state_d         = S_FETCH_HI;
          end
        endcase
      end

      S_3: begin
        case (cls)
          CL_PUSH, CL_PUSHF, CL_RCALL: begin
            strb.sp_write = 1'b1;
            state_d       = S_4;
          end
          CL_POP, CL_POPF, CL_RET: begin
            strb.mem_read = 1'b1;
            if (bus.mem_ready) begin
              strb.reg_write   = (cls == CL_POP);
              strb.flags_write = (cls == CL_POPF);
              strb.pc_write    = (cls == CL_RET);
              strb.instr_done  = 1'b1;
              state_d          = S_FETCH_HI;
            end
          end
          default: begin
            strb.instr_done = 1'b1;
            state_d         = S_FETCH_HI;
          end
        endcase
      end

      S_4: begin
        case (cls)
          CL_PUSH, CL_PUSHF, CL_RCALL: begin
            strb.mem_write = 1'b1;
            if (bus.mem_ready) begin
              if (cls == CL_RCALL) begin
                state_d = S_5;
              end else begin
                strb.instr_done = 1'b1;
                state_d         = S_FETCH_HI;
              end
            end
          end
          default: begin
            strb.instr_done = 1'b1;
            state_d         = S_FETCH_HI;
          end
        endcase
      end

      S_5: begin
        strb.pc_write   = (cls == CL_RCALL);
        strb.instr_done = 1'b1;
        state_d         = S_FETCH_HI;
      end

      default: begin
        state_d = S_FETCH_HI;
      end
    endcase

    // Reset abandons any step or pending access and silences every strobe
    if (reset) begin
      state_d = S_FETCH_HI;
      strb    = '0;
    end
  end

  assign bus.state       = STATE_WIDTH'(state_q);
  assign bus.mem_read    = strb.mem_read;
  assign bus.mem_write   = strb.mem_write;
  assign bus.ir_hi_we    = strb.ir_hi_we;
  assign bus.ir_lo_we    = strb.ir_lo_we;
  assign bus.pc_inc      = strb.pc_inc;
  assign bus.pc_write    = strb.pc_write;
  assign bus.sp_write    = strb.sp_write;
  assign bus.reg_write   = strb.reg_write;
  assign bus.flags_write = strb.flags_write;
  assign bus.instr_done  = strb.instr_done;
  assign bus.illegal     = strb.illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: each driven cycle queues the expected
// step and strobe vector; a negedge checker pops and compares.
module tb_control_sequencer;
  import cpu_pkg::*;

  // Strobe vector bit masks: {mr,mw,irh,irl,pci,pw,spw,rw,fw,done,ill}
  localparam logic [10:0] NONE = 11'b000_0000_0000;
  localparam logic [10:0] MR   = 11'b100_0000_0000;
  localparam logic [10:0] MW   = 11'b010_0000_0000;
  localparam logic [10:0] IRH  = 11'b001_0000_0000;
  localparam logic [10:0] IRL  = 11'b000_1000_0000;
  localparam logic [10:0] PCI  = 11'b000_0100_0000;
  localparam logic [10:0] PW   = 11'b000_0010_0000;
  localparam logic [10:0] SPW  = 11'b000_0001_0000;
  localparam logic [10:0] RW   = 11'b000_0000_1000;
  localparam logic [10:0] FW   = 11'b000_0000_0100;
  localparam logic [10:0] DN   = 11'b000_0000_0010;
  localparam logic [10:0] IL   = 11'b000_0000_0001;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [2:0]  exp_st_q[$];
  logic [10:0] exp_sb_q[$];
  string       tag_q[$];

  control_sequencer_if bus_if ();

  control_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard checker
  always @(negedge clk) begin
    if (exp_st_q.size() != 0) begin
      logic [2:0]  es;
      logic [10:0] eb;
      logic [10:0] ob;
      string       t;
      es = exp_st_q.pop_front();
      eb = exp_sb_q.pop_front();
      t  = tag_q.pop_front();
      ob = {bus_if.mem_read, bus_if.mem_write, bus_if.ir_hi_we, bus_if.ir_lo_we,
            bus_if.pc_inc, bus_if.pc_write, bus_if.sp_write, bus_if.reg_write,
            bus_if.flags_write, bus_if.instr_done, bus_if.illegal};
      checks++;
      assert (bus_if.state === es) else begin
        errors++;
        $error("FAIL %s state observed %0d expected %0d", t, bus_if.state, es);
      end
      checks++;
      assert (ob === eb) else begin
        errors++;
        $error("FAIL %s strobes observed %b expected %b", t, ob, eb);
      end
    end
  end

  // Drive mem_ready for one cycle and queue what the DUT must show in it
  task automatic cyc(input string tag, input logic rdy, input logic [2:0] st,
                     input logic [10:0] sb);
    bus_if.mem_ready = rdy;
    exp_st_q.push_back(st);
    exp_sb_q.push_back(sb);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag);
    cyc({tag, "_s0"}, 1'b1, 3'd0, MR | IRH | PCI);
    cyc({tag, "_s1"}, 1'b1, 3'd1, MR | IRL | PCI);
  endtask

  task automatic set_instr(input opcode_t op, input func_t fn, input logic [3:0] fl);
    bus_if.opcode = op;
    bus_if.func   = fn;
    bus_if.flags  = fl;
  endtask

  task automatic branch(input string tag, input opcode_t op, input logic [3:0] fl,
                        input logic taken);
    set_instr(op, 4'h0, fl);
    fetch(tag);
    cyc({tag, "_s2"}, 1'b0, 3'd2, (taken ? PW : NONE) | DN);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus_if.mem_ready = 1'b1;
    set_instr(RTYPE, ADD, 4'b0000);
    @(posedge clk);
    #1;
    cyc("reset_hold", 1'b1, 3'd0, NONE);
    reset = 1'b0;

    // ADD with fetch stalled two cycles
    cyc("add_wait0", 1'b0, 3'd0, MR);
    cyc("add_wait1", 1'b0, 3'd0, MR);
    cyc("add_s0",    1'b1, 3'd0, MR | IRH | PCI);
    cyc("add_s1",    1'b1, 3'd1, MR | IRL | PCI);
    cyc("add_s2",    1'b1, 3'd2, RW | FW | DN);

    // Compare and immediate forms
    set_instr(RTYPE, CMP, 4'b0000);
    fetch("cmp");
    cyc("cmp_s2", 1'b1, 3'd2, FW | DN);
    set_instr(ADDI, 4'h5, 4'b0000);
    fetch("addi");
    cyc("addi_s2", 1'b1, 3'd2, RW | FW | DN);
    set_instr(CMPI, 4'h3, 4'b0000);
    fetch("cmpi");
    cyc("cmpi_s2", 1'b1, 3'd2, FW | DN);

    // Branches, flags {V,N,C,Z}
    branch("je_t",   JE,  4'b0001, 1'b1);
    branch("je_n",   JE,  4'b0000, 1'b0);
    branch("jne_t",  JNE, 4'b0000, 1'b1);
    branch("jb_t",   JB,  4'b0010, 1'b1);
    branch("jae_n",  JAE, 4'b0010, 1'b0);
    branch("jl_t",   JL,  4'b0100, 1'b1);
    branch("jl_n",   JL,  4'b1100, 1'b0);
    branch("jl_v",   JL,  4'b1000, 1'b1);
    branch("rjmp",   RJMP, 4'b0000, 1'b1);

    // PUSH, no stalls
    set_instr(STACK, SF_PUSH, 4'b0000);
    fetch("push");
    cyc("push_s2", 1'b1, 3'd2, NONE);
    cyc("push_s3", 1'b1, 3'd3, SPW);
    cyc("push_s4", 1'b1, 3'd4, MW | DN);

    // PUSHF with write held off at S4
    set_instr(STACK, SF_PUSHF, 4'b0000);
    fetch("pushf");
    cyc("pushf_s2",  1'b1, 3'd2, NONE);
    cyc("pushf_s3",  1'b1, 3'd3, SPW);
    cyc("pushf_w0",  1'b0, 3'd4, MW);
    cyc("pushf_w1",  1'b0, 3'd4, MW);
    cyc("pushf_s4",  1'b1, 3'd4, MW | DN);

    // POPF with one stall, then POP and RET
    set_instr(STACK, SF_POPF, 4'b0000);
    fetch("popf");
    cyc("popf_s2", 1'b1, 3'd2, SPW);
    cyc("popf_w",  1'b0, 3'd3, MR);
    cyc("popf_s3", 1'b1, 3'd3, MR | FW | DN);
    set_instr(STACK, SF_POP, 4'b0000);
    fetch("pop");
    cyc("pop_s2", 1'b1, 3'd2, SPW);
    cyc("pop_s3", 1'b1, 3'd3, MR | RW | DN);
    set_instr(STACK, SF_RET, 4'b0000);
    fetch("ret");
    cyc("ret_s2", 1'b1, 3'd2, SPW);
    cyc("ret_s3", 1'b1, 3'd3, MR | PW | DN);

    // RCALL full sequence with a stall on the return-address write
    set_instr(RCALL, 4'h0, 4'b0000);
    fetch("rcall");
    cyc("rcall_s2", 1'b1, 3'd2, NONE);
    cyc("rcall_s3", 1'b1, 3'd3, SPW);
    cyc("rcall_w",  1'b0, 3'd4, MW);
    cyc("rcall_s4", 1'b1, 3'd4, MW);
    cyc("rcall_s5", 1'b0, 3'd5, PW | DN);

    // Undefined opcode and undefined R-type func
    set_instr(UNDEF, 4'h0, 4'b0000);
    fetch("undef");
    cyc("undef_s2", 1'b1, 3'd2, IL | DN);
    set_instr(RTYPE, 4'h9, 4'b0000);
    fetch("badfn");
    cyc("badfn_s2", 1'b1, 3'd2, IL | DN);
    cyc("after_ill", 1'b0, 3'd0, MR);
    cyc("after_ill_s0", 1'b1, 3'd0, MR | IRH | PCI);
    cyc("after_ill_s1", 1'b1, 3'd1, MR | IRL | PCI);
    cyc("after_ill_s2", 1'b1, 3'd2, IL | DN);

    // Reset while RCALL's write is pending at S4
    set_instr(RCALL, 4'h0, 4'b0000);
    fetch("rc2");
    cyc("rc2_s2", 1'b1, 3'd2, NONE);
    cyc("rc2_s3", 1'b1, 3'd3, SPW);
    cyc("rc2_w",  1'b0, 3'd4, MW);
    reset = 1'b1;
    cyc("rst_s4",  1'b1, 3'd4, NONE);
    cyc("rst_s0",  1'b1, 3'd0, NONE);
    reset = 1'b0;
    set_instr(ADDI, 4'h1, 4'b0000);
    fetch("post_rst");
    cyc("post_rst_s2", 1'b1, 3'd2, RW | FW | DN);
    cyc("post_rst_idle", 1'b0, 3'd0, MR);

    @(negedge clk);
    #1;
    checks++;
    assert (exp_st_q.size() == 0) else begin
      errors++;
      $error("FAIL drain pending observed %0d expected 0", exp_st_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
